// File: rtl/bus_reader_pkg.sv
// -----------------------------------------------------------------------------
// bus_reader_pkg
// Shared definitions for the single-wire tristate bus reader: the scan FSM
// state encoding, the vote length and the 3-input majority function used to
// reject single-cycle glitches on the bus.
// -----------------------------------------------------------------------------
package bus_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAP    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Number of synchronised samples voted per source.
  localparam int unsigned VOTE_LEN = 3;

  // Two equal samples out of three decide the result.
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/bus_reader_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// N-stage flip-flop synchroniser for a single asynchronous input bit.
// Reused for other pin inputs at the top level.
// Ports:
//   i_clk  in  1  destination clock
//   i_rst  in  1  asynchronous active-high reset, clears every stage
//   i_d    in  1  asynchronous input
//   o_q    out 1  input synchronised to i_clk (SYNC_STAGES cycles of latency)
// -----------------------------------------------------------------------------
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_pipe;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= {r_pipe[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/bus_reader.sv
// -----------------------------------------------------------------------------
// bus_reader
// Owns the one-hot enables of N_SRC tristate drivers sharing one bus wire and
// scans them in order. For each source it enables the driver, waits for the
// bus and the synchroniser to settle, majority-votes three synchronised
// samples and stores the result in bus_val[idx]. A one-cycle valid pulse
// marks a completed scan.
// Ports:
//   CLK       in   1      system clock, all state on rising edge
//   RST       in   1      asynchronous active-high reset
//   start     in   1      request one full scan, only honoured in IDLE
//   data_bus  in   1      shared bus wire, asynchronous to CLK
//   sel       out  N_SRC  registered one-hot driver enable, 0 = bus released
//   bus_val   out  N_SRC  voted value per source from the last scan
//   valid     out  1      one-cycle pulse in the DONE cycle
//   busy      out  1      high while a scan is in progress (through DONE)
// -----------------------------------------------------------------------------
module bus_reader
  import bus_reader_pkg::*;
#(
  parameter int N_SRC         = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             data_bus,
  output logic [N_SRC-1:0] sel,
  output logic [N_SRC-1:0] bus_val,
  output logic             valid,
  output logic             busy
);

  // The settle window also covers the synchroniser fill so that the first
  // voted sample already reflects the enabled driver.
  localparam int SETTLE_LEN = SETTLE_CYCLES + SYNC_STAGES;
  localparam int CNT_RANGE  = (SETTLE_LEN > VOTE_LEN) ? SETTLE_LEN : VOTE_LEN;
  localparam int CNT_W      = (CNT_RANGE > 1) ? $clog2(CNT_RANGE) : 1;
  localparam int IDX_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(VOTE_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_SRC - 1);
  localparam logic [N_SRC-1:0] SEL_ONE     = N_SRC'(1);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx,   w_idx_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]       r_vote,  w_vote_nxt;
  logic [N_SRC-1:0] r_bus_val, w_bus_val_nxt;
  logic [N_SRC-1:0] r_sel,   w_sel_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             w_sync;

  sync_ff #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (data_bus),
    .o_q   (w_sync)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_vote    <= '0;
      r_bus_val <= '0;
      r_sel     <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_vote    <= w_vote_nxt;
      r_bus_val <= w_bus_val_nxt;
      r_sel     <= w_sel_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_vote_nxt    = r_vote;
    w_bus_val_nxt = r_bus_val;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_GAP;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_SETTLE;
        w_cnt_nxt   = '0;
      end
      ST_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = ST_SAMPLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        w_vote_nxt = {r_vote[1:0], w_sync};
        if (r_cnt == SAMPLE_LAST) begin
          // The third sample is voted in the same cycle it is shifted in.
          w_bus_val_nxt[r_idx] = majority3(w_vote_nxt);
          w_cnt_nxt            = '0;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = ST_GAP;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with the
    // state register and never glitch toward the pad drivers. GAP and DONE
    // force sel to zero, which gives break-before-make between sources.
    w_sel_nxt   = '0;
    if ((w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE)) begin
      w_sel_nxt = SEL_ONE << w_idx_nxt;
    end
    w_valid_nxt = (w_state_nxt == ST_DONE);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
  end

  assign sel     = r_sel;
  assign bus_val = r_bus_val;
  assign valid   = r_valid;
  assign busy    = r_busy;

endmodule

// File: tb/tb_bus_reader.sv
// -----------------------------------------------------------------------------
// tb_bus_reader
// Directed bench for bus_reader: a default 2-source instance and a 4-source
// instance (SETTLE_CYCLES=1). Each source i drives bit i of a stimulus vector
// onto the bus while sel[i] is high; the released bus reads 0.
// Edge k counts rising edges after the edge that accepts start (edge 0);
// outputs are observed 1 time unit after edge k, so a value seen after edge k
// is the value sampled by edge k+1.
// -----------------------------------------------------------------------------
module tb_bus_reader;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic       start;
  logic       start4;
  logic [1:0] src;
  logic       glitch_low;
  logic [3:0] src4;

  logic       data_bus;
  logic [1:0] sel;
  logic [1:0] bus_val;
  logic       valid;
  logic       busy;

  logic       data_bus4;
  logic [3:0] sel4;
  logic [3:0] bus_val4;
  logic       valid4;
  logic       busy4;

  int checks = 0;
  int errors = 0;

  // Bus model: enabled driver puts its value on the wire; glitch_low pulls
  // source 0's contribution low while it is set.
  assign data_bus  = |(sel & (src & {1'b1, ~glitch_low}));
  assign data_bus4 = |(sel4 & src4);

  bus_reader u_dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .data_bus (data_bus),
    .sel      (sel),
    .bus_val  (bus_val),
    .valid    (valid),
    .busy     (busy)
  );

  bus_reader #(
    .N_SRC         (4),
    .SETTLE_CYCLES (1),
    .SYNC_STAGES   (2)
  ) u_dut4 (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start4),
    .data_bus (data_bus4),
    .sel      (sel4),
    .bus_val  (bus_val4),
    .valid    (valid4),
    .busy     (busy4)
  );

  // Expected sel after edge k: each slot of l edges keeps the driver on for
  // l-1 edges, then one edge with the bus released (GAP or DONE).
  function automatic logic [3:0] exp_sel_f(input int k, input int n, input int l);
    logic [3:0] one;
    int slot;
    int pos;
    one = 4'b0001;
    if (k < 1 || k > n * l) return 4'b0000;
    slot = (k - 1) / l;
    pos  = (k - 1) % l;
    if (pos == l - 1) return 4'b0000;
    return one << slot;
  endfunction

  // Every cycle: at most one enable, and never a direct handover between two
  // different enables across one edge.
  logic [1:0] prev_sel  = 2'b00;
  logic [3:0] prev_sel4 = 4'b0000;
  always @(negedge CLK) begin
    checks++;
    assert ($onehot0(sel) && $onehot0(sel4)) else begin
      errors++;
      $display("FAIL onehot0_sel: sel=%b sel4=%b, required at most one bit set", sel, sel4);
    end
    checks++;
    if ((prev_sel != 2'b00 && sel != 2'b00 && prev_sel != sel) ||
        (prev_sel4 != 4'b0000 && sel4 != 4'b0000 && prev_sel4 != sel4)) begin
      errors++;
      $display("FAIL break_before_make: sel %b->%b sel4 %b->%b, required a zero cycle between",
               prev_sel, sel, prev_sel4, sel4);
    end
    prev_sel  = sel;
    prev_sel4 = sel4;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  // Full 2-source scan with per-edge checks of sel/valid/busy; optional glitch
  // on source 0 set after edge g0 and removed after edge g1.
  task automatic run_scan(input logic [1:0] s, input int g0, input int g1,
                          input logic [1:0] exp_bv, input string name);
    logic [1:0] es;
    logic       ev;
    logic       eb;
    src        = s;
    glitch_low = 1'b0;
    start      = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1 || sel !== 2'b00) begin
      errors++;
      $display("FAIL %s_accept: busy=%b sel=%b, required busy=1 sel=00", name, busy, sel);
    end
    for (int k = 1; k <= 24; k++) begin
      @(posedge CLK);
      #1;
      es = exp_sel_f(k, 2, 10) & 4'b0011;
      ev = (k == 20);
      eb = (k <= 20);
      checks++;
      if (sel !== es || valid !== ev || busy !== eb) begin
        errors++;
        $display("FAIL %s_edge%0d: sel=%b valid=%b busy=%b, required sel=%b valid=%b busy=%b",
                 name, k, sel, valid, busy, es, ev, eb);
      end
      glitch_low = (k >= g0 && k < g1);
    end
    glitch_low = 1'b0;
    checks++;
    if (bus_val !== exp_bv) begin
      errors++;
      $display("FAIL %s_bus_val: got %b, required %b", name, bus_val, exp_bv);
    end
  endtask

  task automatic test_reset();
    RST        = 1'b1;
    start      = 1'b0;
    start4     = 1'b0;
    src        = 2'b00;
    src4       = 4'b0000;
    glitch_low = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({sel, bus_val, valid, busy} !== 6'b0 || {sel4, bus_val4, valid4, busy4} !== 10'b0) begin
      errors++;
      $display("FAIL reset_state: sel=%b bus_val=%b valid=%b busy=%b sel4=%b bus_val4=%b valid4=%b busy4=%b, required all 0",
               sel, bus_val, valid, busy, sel4, bus_val4, valid4, busy4);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    run_scan(2'b01, 0, 0, 2'b01, "basic");
  endtask

  // Source 0 samples are taken from the bus at edges 6, 7, 8.
  task automatic test_glitch();
    run_scan(2'b01, 6, 8, 2'b00, "glitch_two_low");
    run_scan(2'b01, 6, 7, 2'b01, "glitch_one_low");
  endtask

  task automatic test_reset_mid_scan();
    int nvalid;
    src   = 2'b01;
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (13) @(posedge CLK);
    #1;
    checks++;
    if (sel !== 2'b10 || bus_val !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_before: sel=%b bus_val=%b, required sel=10 bus_val=01", sel, bus_val);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (sel !== 2'b00 || bus_val !== 2'b00 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: sel=%b bus_val=%b valid=%b busy=%b, required all 0",
               sel, bus_val, valid, busy);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST    = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge CLK);
      #1;
      if (valid === 1'b1 || busy === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: %0d cycles with valid/busy, required 0", nvalid);
    end
    run_scan(2'b01, 0, 0, 2'b01, "rstmid_restart");
  endtask

  task automatic test_start_while_busy();
    int nvalid;
    int vpos;
    src    = 2'b10;
    nvalid = 0;
    vpos   = -1;
    start  = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge CLK);
      #1;
      if (valid === 1'b1) begin
        nvalid++;
        vpos = k;
      end
      // Raised after edges 4 and 11 so edges 5 and 12 sample it.
      start = (k == 4 || k == 11);
    end
    start = 1'b0;
    checks++;
    if (nvalid != 1 || vpos != 20) begin
      errors++;
      $display("FAIL busy_start_ignored: %0d valid pulses last at edge %0d, required 1 at edge 20",
               nvalid, vpos);
    end
    checks++;
    if (bus_val !== 2'b10) begin
      errors++;
      $display("FAIL busy_start_bus_val: got %b, required 10", bus_val);
    end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    int pos0;
    int pos1;
    int waited;
    src    = 2'b11;
    nvalid = 0;
    pos0   = -1;
    pos1   = -1;
    start  = 1'b1;
    @(posedge CLK);
    for (int k = 1; k <= 60; k++) begin
      @(posedge CLK);
      #1;
      if (valid === 1'b1) begin
        if (nvalid == 0) pos0 = k;
        else if (nvalid == 1) pos1 = k;
        nvalid++;
      end
    end
    start = 1'b0;
    checks++;
    if (nvalid != 2 || pos0 != 20 || pos1 != 42) begin
      errors++;
      $display("FAIL back_to_back: %0d pulses at %0d,%0d, required 2 at 20,42", nvalid, pos0, pos1);
    end
    waited = 0;
    while (busy === 1'b1 && waited < 30) begin
      @(posedge CLK);
      #1;
      waited++;
    end
    checks++;
    if (busy !== 1'b0 || bus_val !== 2'b11) begin
      errors++;
      $display("FAIL back_to_back_drain: busy=%b bus_val=%b, required busy=0 bus_val=11", busy, bus_val);
    end
  endtask

  task automatic test_four_sources();
    logic [3:0] es;
    logic       ev;
    src4   = 4'b1010;
    start4 = 1'b1;
    @(posedge CLK);
    #1 start4 = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge CLK);
      #1;
      es = exp_sel_f(k, 4, 7);
      ev = (k == 28);
      checks++;
      if (sel4 !== es || valid4 !== ev || busy4 !== (k <= 28)) begin
        errors++;
        $display("FAIL four_src_edge%0d: sel4=%b valid4=%b busy4=%b, required sel4=%b valid4=%b busy4=%b",
                 k, sel4, valid4, busy4, es, ev, (k <= 28));
      end
    end
    checks++;
    if (bus_val4 !== 4'b1010) begin
      errors++;
      $display("FAIL four_src_bus_val: got %b, required 1010", bus_val4);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_reset_mid_scan();
    test_start_while_busy();
    test_back_to_back();
    test_four_sources();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
